// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback, and drives the datapath enables and mux selects.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       instr_retired,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsNone,
    ClsAluR,
    ClsAluI,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsLui,
    ClsAuipc,
    ClsFence,
    ClsIllegal
  } cls_e;

  // PC+4 / ALU result / ALU result with bit 0 cleared
  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcAlu    = 2'd1;
  localparam logic [1:0] PcAluAln = 2'd2;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbLoad = 2'd1;
  localparam logic [1:0] WbPc4  = 2'd2;
  localparam logic [1:0] WbImm  = 2'd3;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d, dec_cls;
  logic   op_a_pc, op_b_imm;

  // Opcode to instruction class; anything unrecognised (SYSTEM included) traps.
  always_comb begin
    dec_cls = ClsIllegal;
    case (opcode)
      7'b0110011: dec_cls = ClsAluR;
      7'b0010011: dec_cls = ClsAluI;
      7'b0000011: dec_cls = ClsLoad;
      7'b0100011: dec_cls = ClsStore;
      7'b1100011: dec_cls = ClsBranch;
      7'b1101111: dec_cls = ClsJal;
      7'b1100111: dec_cls = ClsJalr;
      7'b0110111: dec_cls = ClsLui;
      7'b0010111: dec_cls = ClsAuipc;
      7'b0001111: dec_cls = ClsFence;
      default:    dec_cls = ClsIllegal;
    endcase
  end

  // ALU operand selects by latched class; held through MEM and WB so the result stays valid.
  always_comb begin
    op_a_pc  = 1'b0;
    op_b_imm = 1'b0;
    case (cls_q)
      ClsAluI, ClsLoad, ClsStore, ClsJalr: op_b_imm = 1'b1;
      ClsAuipc, ClsJal, ClsBranch: begin
        op_a_pc  = 1'b1;
        op_b_imm = 1'b1;
      end
      default: ;
    endcase
  end

  // State and class registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cls_q   <= ClsNone;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next-state and datapath controls.
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_is_fetch  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = PcPlus4;
    rf_we         = 1'b0;
    wb_sel        = WbAlu;
    alu_a_sel     = 1'b0;
    alu_b_sel     = 1'b0;
    instr_retired = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end

      StDecode: begin
        cls_d = dec_cls;
        case (dec_cls)
          ClsIllegal: state_d = StTrap;
          ClsFence: begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_d       = StFetch;
          end
          default: state_d = StExec;
        endcase
      end

      StExec: begin
        alu_a_sel = op_a_pc;
        alu_b_sel = op_b_imm;
        case (cls_q)
          ClsBranch: begin
            pc_we         = 1'b1;
            pc_sel        = branch_taken ? PcAlu : PcPlus4;
            instr_retired = 1'b1;
            state_d       = StFetch;
          end
          ClsLoad, ClsStore: state_d = StMem;
          ClsAluR, ClsAluI, ClsJalr, ClsAuipc, ClsJal, ClsLui: state_d = StWb;
          default: state_d = StTrap;
        endcase
      end

      StMem: begin
        mem_req   = 1'b1;
        mem_we    = (cls_q == ClsStore);
        alu_a_sel = op_a_pc;
        alu_b_sel = op_b_imm;
        if (mem_ready) begin
          if (cls_q == ClsStore) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_d       = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end

      StWb: begin
        rf_we         = 1'b1;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        alu_a_sel     = op_a_pc;
        alu_b_sel     = op_b_imm;
        state_d       = StFetch;
        case (cls_q)
          ClsLoad:         wb_sel = WbLoad;
          ClsJal, ClsJalr: wb_sel = WbPc4;
          ClsLui:          wb_sel = WbImm;
          default:         wb_sel = WbAlu;
        endcase
        case (cls_q)
          ClsJal:  pc_sel = PcAlu;
          ClsJalr: pc_sel = PcAluAln;
          default: pc_sel = PcPlus4;
        endcase
      end

      StTrap: illegal = 1'b1;

      default: state_d = StFetch;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each directed
// instruction into its expected per-cycle output schedule, which is then
// driven and compared cycle by cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, branch_taken, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, mem_is_fetch, ir_we, pc_we, rf_we;
  logic [1:0] pc_sel, wb_sel;
  logic       alu_a_sel, alu_b_sel, instr_retired, illegal;
  logic [2:0] state;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_is_fetch (mem_is_fetch),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .instr_retired(instr_retired),
    .illegal      (illegal),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, fetch, irwe, pcwe;
    logic [1:0] pcsel;
    logic       rfwe;
    logic [1:0] wbsel;
    logic       asel, bsel, ret, ill;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [6:0] op;
    logic       bt;
    bit         chk;
    exp_t       e;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   failures = 0;

  localparam logic [31:0] IAddi  = 32'h00500093;
  localparam logic [31:0] ILw    = 32'h0000A103;
  localparam logic [31:0] IBeq   = 32'h00000463;
  localparam logic [31:0] IJalr  = 32'h000080E7;
  localparam logic [31:0] ISw    = 32'h0020A023;
  localparam logic [31:0] IAdd   = 32'h002081B3;
  localparam logic [31:0] ILui   = 32'h123452B7;
  localparam logic [31:0] IAuipc = 32'h00000317;
  localparam logic [31:0] IJal   = 32'h008000EF;
  localparam logic [31:0] IFence = 32'h0000000F;
  localparam logic [31:0] IEcall = 32'h00000073;

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input exp_t e, input logic rst, input logic rdy,
                               input logic [6:0] op, input logic bt, input bit chk);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.op = op; c.bt = bt; c.chk = chk; c.e = e;
    q.push_back(c);
  endfunction

  // Expand one instruction into the cycles it must take. fw/mw are wait cycles
  // before mem_ready in fetch and in the data access. Illegal opcodes stop after DECODE.
  function automatic void add_instr(input logic [31:0] ins, input logic bt,
                                    input int fw, input int mw);
    logic [6:0] op;
    string      k;
    logic       a, b;
    exp_t       e;
    op = ins[6:0];
    case (op)
      7'h33: k = "r";     7'h13: k = "i";     7'h03: k = "ld";   7'h23: k = "st";
      7'h63: k = "br";    7'h6F: k = "jal";   7'h67: k = "jalr"; 7'h37: k = "lui";
      7'h17: k = "auipc"; 7'h0F: k = "fence"; default: k = "ill";
    endcase
    a = (k == "auipc" || k == "jal" || k == "br");
    b = a || k == "i" || k == "ld" || k == "st" || k == "jalr";

    // fetch: opcode bus carries garbage until the IR is written
    for (int i = 0; i < fw; i++) begin
      e = blank(3'd0); e.req = 1; e.fetch = 1;
      push(e, 1, 0, 7'h00, rnd_bit(), 1);
    end
    e = blank(3'd0); e.req = 1; e.fetch = 1; e.irwe = 1;
    push(e, 1, 1, 7'h00, rnd_bit(), 1);

    e = blank(3'd1);
    if (k == "fence") begin e.pcwe = 1; e.ret = 1; end
    push(e, 1, rnd_bit(), op, bt, 1);
    if (k == "ill" || k == "fence") return;

    e = blank(3'd2); e.asel = a; e.bsel = b;
    if (k == "br") begin
      e.pcwe = 1; e.ret = 1; e.pcsel = bt ? 2'd1 : 2'd0;
      push(e, 1, rnd_bit(), op, bt, 1);
      return;
    end
    push(e, 1, rnd_bit(), op, bt, 1);

    if (k == "ld" || k == "st") begin
      for (int i = 0; i < mw; i++) begin
        e = blank(3'd3); e.req = 1; e.we = (k == "st"); e.asel = a; e.bsel = b;
        push(e, 1, 0, op, bt, 1);
      end
      e = blank(3'd3); e.req = 1; e.we = (k == "st"); e.asel = a; e.bsel = b;
      if (k == "st") begin e.pcwe = 1; e.ret = 1; end
      push(e, 1, 1, op, bt, 1);
      if (k == "st") return;
    end

    e = blank(3'd4); e.rfwe = 1; e.pcwe = 1; e.ret = 1; e.asel = a; e.bsel = b;
    if (k == "ld") e.wbsel = 2'd1;
    else if (k == "jal" || k == "jalr") e.wbsel = 2'd2;
    else if (k == "lui") e.wbsel = 2'd3;
    if (k == "jal") e.pcsel = 2'd1;
    else if (k == "jalr") e.pcsel = 2'd2;
    push(e, 1, rnd_bit(), op, bt, 1);
  endfunction

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    int   base;
    int   retired;
    int   addi_st[4];
    exp_t e, g;
    cyc_t c;

    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; branch_taken = 1'b0;
    addi_st = '{0, 1, 2, 4};

    // Two reset cycles; by the second the FSM must already present FETCH.
    push(blank(3'd0), 0, 0, 7'h00, 0, 0);
    e = blank(3'd0); e.req = 1; e.fetch = 1;
    push(e, 0, 0, 7'h00, 0, 1);

    base = q.size();
    add_instr(IAddi, 0, 0, 0);
    check_int("addi_cycles", q.size() - base, 4);
    for (int i = 0; i < 4; i++) check_int("addi_state_seq", int'(q[base+i].e.st), addi_st[i]);
    check_int("addi_wb_rf_we", int'(q[base+3].e.rfwe), 1);
    check_int("addi_wb_sel", int'(q[base+3].e.wbsel), 0);
    check_int("addi_wb_b_sel", int'(q[base+3].e.bsel), 1);
    check_int("addi_wb_pc_sel", int'(q[base+3].e.pcsel), 0);

    base = q.size();
    add_instr(ILw, 0, 0, 3);
    check_int("lw_cycles", q.size() - base, 8);
    check_int("lw_wb_sel", int'(q[base+7].e.wbsel), 1);

    base = q.size();
    add_instr(IBeq, 1, 0, 0);
    check_int("beq_taken_cycles", q.size() - base, 3);
    check_int("beq_taken_pc_sel", int'(q[base+2].e.pcsel), 1);
    base = q.size();
    add_instr(IBeq, 0, 1, 0);
    check_int("beq_not_taken_pc_sel", int'(q[base+3].e.pcsel), 0);

    base = q.size();
    add_instr(IJalr, 0, 0, 0);
    check_int("jalr_wb_pc_sel", int'(q[base+3].e.pcsel), 2);
    check_int("jalr_wb_sel", int'(q[base+3].e.wbsel), 2);

    base = q.size();
    add_instr(ISw, 0, 0, 0);
    check_int("sw_cycles", q.size() - base, 4);
    check_int("sw_mem_we", int'(q[base+3].e.we), 1);

    add_instr(IAdd, 0, 2, 0);
    add_instr(ILui, 0, 0, 0);
    add_instr(IAuipc, 0, 1, 0);
    add_instr(IJal, 0, 0, 0);
    base = q.size();
    add_instr(IFence, 0, 0, 0);
    check_int("fence_cycles", q.size() - base, 2);

    // Load whose data access is cut by reset on its second wait cycle.
    add_instr(ILw, 0, 0, 5);
    for (int i = 0; i < 5; i++) void'(q.pop_back());
    c = q[$]; c.rst = 0; q[$] = c;
    add_instr(IAddi, 0, 0, 0);

    // ecall traps and sits there until reset, ignoring mem_ready.
    add_instr(IEcall, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      e = blank(3'd5); e.ill = 1;
      push(e, 1, rnd_bit(), 7'h73, rnd_bit(), 1);
    end
    e = blank(3'd5); e.ill = 1;
    push(e, 0, 1, 7'h73, 0, 1);
    add_instr(IAddi, 0, 0, 0);

    retired = 0;
    foreach (q[i]) begin
      @(negedge clk);
      rst_n = q[i].rst; mem_ready = q[i].rdy; opcode = q[i].op; branch_taken = q[i].bt;
      #1;
      g.st = state; g.req = mem_req; g.we = mem_we; g.fetch = mem_is_fetch; g.irwe = ir_we;
      g.pcwe = pc_we; g.pcsel = pc_sel; g.rfwe = rf_we; g.wbsel = wb_sel;
      g.asel = alu_a_sel; g.bsel = alu_b_sel; g.ret = instr_retired; g.ill = illegal;
      if (q[i].chk) begin
        checks++;
        if (g !== q[i].e) begin
          failures++;
          $display("FAIL cycle%0d outputs: got=%05h want=%05h (state %0d, want %0d)",
                   i, g, q[i].e, state, q[i].e.st);
        end
      end
      if (instr_retired === 1'b1) retired++;
    end
    @(negedge clk);
    check_int("retired_total", retired, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback over a shared ALU and a single memory port. It drives the enables and mux selects for the PC, the instruction register, the register file, the ALU operand muxes and the memory port. Immediate decoding stays in the immediate generator, which reads the opcode directly.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- opcode  in  7  IR[6:0], valid from DECODE onward
- branch_taken  in  1  comparator result for rs1/rs2/funct3, sampled in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = store
- mem_is_fetch  out  1  address source: 1 = PC, 0 = ALU result
- ir_we  out  1  write the instruction register
- pc_we  out  1  write the PC
- pc_sel  out  2  0 = PC+4, 1 = ALU result, 2 = ALU result & ~1
- rf_we  out  1  register file write
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = immediate
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- instr_retired  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky; high in TRAP
- state  out  3  current state, for debug

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Outputs are combinational from the state register plus a 4-bit class register. Every output not listed for a state is 0.
- Classes are latched in DECODE from opcode:
  - ALU_R 0110011, ALU_I 0010011, LOAD 0000011, STORE 0100011
  - BRANCH 1100011, JAL 1101111, JALR 1100111
  - LUI 0110111, AUIPC 0010111, FENCE 0001111
  - Any other opcode, including SYSTEM, is ILLEGAL.
- FETCH: mem_req=1, mem_is_fetch=1.
  - When mem_ready: ir_we=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch the class.
  - ILLEGAL → TRAP.
  - FENCE: pc_we=1, pc_sel=0, instr_retired=1, next FETCH.
  - All other classes → EXEC.
- EXEC, by class:
  - ALU_R: a=rs1, b=rs2 → WB.
  - ALU_I, LOAD, STORE, JALR: a=rs1, b=imm. LOAD/STORE → MEM; others → WB.
  - AUIPC, JAL: a=PC, b=imm → WB.
  - LUI: → WB.
  - BRANCH: a=PC, b=imm, pc_we=1, pc_sel = branch_taken ? 1 : 0, instr_retired=1, next FETCH.
- MEM: mem_req=1, mem_is_fetch=0, operands as in EXEC, mem_we=1 for STORE.
  - While !mem_ready: stay in MEM.
  - LOAD on mem_ready → WB.
  - STORE on mem_ready: pc_we=1, pc_sel=0, instr_retired=1, next FETCH.
- WB: rf_we=1, pc_we=1, instr_retired=1, next FETCH. Operands as in EXEC, so the ALU result stays valid.
  - wb_sel: 0 for ALU_R, ALU_I, AUIPC; 1 for LOAD; 2 for JAL, JALR; 3 for LUI.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
  - rd=x0 suppression is done by the register file, not here.
- TRAP: all outputs 0 except illegal=1. Held until reset.
- mem_ready is ignored whenever mem_req=0.

## Timing
- Reset: when rst_n=0 at a rising edge, next state is FETCH, class is cleared, illegal=0. All outputs other than those driven by FETCH are 0 in the first cycle after reset. Reset mid-request drops mem_req's transaction; the PC is not written.
- Cycles per instruction with zero-wait memory (mem_ready in the same cycle as mem_req):
  - FENCE 2, BRANCH 3.
  - ALU_R, ALU_I, LUI, AUIPC, JAL, JALR, STORE 4.
  - LOAD 5.
- Each wait cycle of mem_ready adds one cycle to FETCH or MEM.
- mem_req stays asserted continuously from the first request cycle through the mem_ready cycle.
- Per instruction, pc_we and instr_retired each pulse exactly once, in the same cycle.

## Test plan
- Reset with rst_n=0 for 2 cycles, then fetch `addi` (0x00500093) with mem_ready tied high → state sequence 0,1,2,4,0. Verify rf_we=1, wb_sel=0, alu_b_sel=1, pc_sel=0 in WB, and instr_retired pulses on cycle 4.
- `lw` (0x0000A103) with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles with mem_we=0, then WB with wb_sel=1. Total 8 cycles.
- `beq` (0x00000463):
  - branch_taken=1 → pc_we=1, pc_sel=1 in EXEC, 3 cycles total.
  - Repeat with branch_taken=0 → pc_sel=0.
- `jalr` (0x000080E7) → WB has wb_sel=2, pc_sel=2, rf_we=1. `sw` (0x0020A023) → MEM has mem_we=1, and rf_we is never asserted.
- Opcode 0x73 (ecall) → TRAP after DECODE, illegal=1. Stays in TRAP for 20 cycles, with mem_req staying 0. rst_n low for one cycle → back to FETCH with illegal=0.
- rst_n low during a MEM wait → next state is FETCH, and pc_we and rf_we are not asserted.
